// File: rtl/mul_mod_pipe.sv
// rtl/mul_mod_pipe.sv - four-stage Barrett modular multiplier, (a*w) mod 12587009
// Optional input range check enabled by defining MUL_MOD_RANGE_CHECK_EN.
module mul_mod_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [23:0] in_a,
   input  logic [23:0] in_w,
   input  logic [7:0]  in_tag,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [23:0] out_p,
   output logic [7:0]  out_tag,
   output logic        busy,
   output logic        err
);

   localparam logic [23:0] Q  = 24'd12587009;
   localparam logic [24:0] MU = 25'd22362340;

   logic        adv;
   logic        s1_valid, s2_valid, s3_valid, s4_valid;
   logic [23:0] s1_a, s1_w;
   logic [7:0]  s1_tag, s2_tag, s3_tag, s4_tag;
   logic [47:0] s2_p;
   logic [25:0] s3_r;
   logic [23:0] s4_p;

   logic [49:0] qhat_full;
   logic [24:0] qhat;
   logic [48:0] qhat_q;
   logic [25:0] r_est;
   logic [25:0] r1;
   logic [23:0] r_fin;

   assign adv       = !s4_valid || out_ready;
   assign in_ready  = adv;
   assign out_valid = s4_valid;
   assign out_p     = s4_p;
   assign out_tag   = s4_tag;
   assign busy      = s1_valid || s2_valid || s3_valid || s4_valid;

   // Barrett estimate undershoots the true quotient by at most 2, so r < 3q fits in 26 bits
   assign qhat_full = {25'd0, s2_p[47:23]} * {25'd0, MU};
   assign qhat      = 25'(qhat_full >> 25);
   assign qhat_q    = {24'd0, qhat} * {25'd0, Q};
   assign r_est     = s2_p[25:0] - 26'(qhat_q);

   always_comb begin
      r1 = s3_r;
      if (r1 >= {2'b00, Q}) r1 = r1 - {2'b00, Q};
      r_fin = r1[23:0];
      if (r1 >= {2'b00, Q}) r_fin = 24'(r1 - {2'b00, Q});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
         s4_valid <= 1'b0;
         s4_p     <= '0;
         s4_tag   <= '0;
      end else if (adv) begin
         s1_valid <= in_valid;
         s1_a     <= in_a;
         s1_w     <= in_w;
         s1_tag   <= in_tag;
         s2_valid <= s1_valid;
         s2_p     <= {24'd0, s1_a} * {24'd0, s1_w};
         s2_tag   <= s1_tag;
         s3_valid <= s2_valid;
         s3_r     <= r_est;
         s3_tag   <= s2_tag;
         s4_valid <= s3_valid;
         s4_p     <= r_fin;
         s4_tag   <= s3_tag;
      end
   end

`ifdef MUL_MOD_RANGE_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst)
         err <= 1'b0;
      else if (in_valid && adv && (in_a >= Q || in_w >= Q))
         err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule
